s_axil_register: RTL and testbench
==================================

S_AXIL_REGISTER -- requirements
Module: s_axil_register

Interface
REQ-001 SHALL have parameter S_AXI_ADDR_WIDTH, default 6, byte-address width.
REQ-002 SHALL have parameter S_AXI_DATA_WIDTH, default 32, data width; WSTRB width is S_AXI_DATA_WIDTH/8.
REQ-003 SHALL have ACLK, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have ARESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have AWADDR input [ADDR_W]; AWVALID input 1; AWREADY output 1: write-address channel.
REQ-006 SHALL have WDATA input [DATA_W]; WSTRB input [DATA_W/8]; WVALID input 1; WREADY output 1: write-data channel.
REQ-007 SHALL have BRESP output 2; BVALID output 1; BREADY input 1: write-response channel.
REQ-008 SHALL have ARADDR input [ADDR_W]; ARVALID input 1; ARREADY output 1: read-address channel.
REQ-009 SHALL have RDATA output [DATA_W]; RRESP output 2; RVALID output 1; RREADY input 1: read-data channel.

Function
REQ-010 SHALL implement 2^ADDR_W/(DATA_W/8) registers of DATA_W bits (16 x 32 by default), indexed by address bits [ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits ignored.
REQ-011 SHALL give every address a register; no decode errors; BRESP and RRESP always 2'b00 (OKAY).
REQ-012 All outputs SHALL be registered.
REQ-013 Write path SHALL capture AW and W independently: AWREADY high while no address held and BVALID low; an AWVALID&AWREADY edge latches AWADDR and drops AWREADY; W likewise latches WDATA/WSTRB and drops WREADY.
REQ-014 AW and W SHALL be accepted in either order or on the same edge.
REQ-015 On the first edge at which both address and data are held, the addressed register SHALL be updated byte-wise (byte i written iff WSTRB[i]=1) and BVALID SHALL rise on that same edge; latency from last of the AW/W handshakes to BVALID is one cycle.
REQ-016 BVALID SHALL hold until a BVALID&BREADY edge; on that edge BVALID falls and AWREADY and WREADY rise.
REQ-017 WSTRB=0 SHALL complete the handshake with no register change.
REQ-018 Read path: ARREADY high while RVALID low; an ARVALID&ARREADY edge SHALL drop ARREADY, set RVALID=1, and load RDATA with the addressed register (one-cycle latency).
REQ-019 RDATA/RVALID SHALL hold stable until an RVALID&RREADY edge; on that edge RVALID falls and ARREADY rises.
REQ-020 Read and write paths SHALL operate concurrently and independently.
REQ-021 If a read handshake and a write commit hit the same register on the same edge, RDATA SHALL return the pre-write value.
REQ-022 Master SHALL be allowed to hold BREADY/RREADY high in advance; response then completes on the edge after VALID rises.

Reset
REQ-023 ARESET high SHALL immediately clear all registers to 0, BVALID, RVALID, BRESP, RRESP, RDATA to 0, discard any captured address/data, and hold AWREADY, WREADY, ARREADY at 0.
REQ-024 On the first rising ACLK edge after ARESET falls, AWREADY, WREADY, ARREADY SHALL rise to 1.
REQ-025 Reset asserted mid-transaction SHALL abort it with no register update and no response.

Verification
REQ-026 After reset, read addresses 0x00..0x3C -> each RDATA=0x00000000, RRESP=00.
REQ-027 Write 0x04 <= 0xDEADBEEF, WSTRB=0xF, AW and W same cycle -> BVALID one cycle later, BRESP=00; read 0x04 -> 0xDEADBEEF.
REQ-028 Write 0x08 <= 0x11223344 with W three cycles before AW -> single write after AW, BVALID one cycle after AW handshake; read 0x08 -> 0x11223344.
REQ-029 Register 0x0C=0xFFFFFFFF, write 0x0C <= 0x00000000 WSTRB=0x5 -> read 0xFF00FF00; write to 0x0D (unaligned) <= 0xAAAAAAAA WSTRB=0xF -> read 0x0C returns 0xAAAAAAAA.
REQ-030 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RDATA stable, AWREADY/WREADY/ARREADY stay 0 until handshake.
REQ-031 Assert ARESET after AW handshake but before W -> all outputs 0 immediately; after release readies return to 1 and target register reads 0.

Source files
------------

// File: rtl/s_axil_register.sv
// AXI4-Lite slave exposing a bank of byte-writable registers.
// Write address and data are captured independently and committed together; the read path runs concurrently.
module s_axil_register #(
  parameter int S_AXI_ADDR_WIDTH = 6,
  parameter int S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int STRB_W   = S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int NUM_REGS = 2 ** IDX_W;

  logic [S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                        aw_held_q, w_held_q;
  logic [IDX_W-1:0]            aw_idx_q;
  logic [S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]           w_strb_q;

  logic aw_hs, w_hs, b_hs, ar_hs, commit;
  logic aw_held_d, w_held_d, bvalid_d, rvalid_d;

  // Every address decodes to a register, so the responses are always OKAY.
  assign BRESP = 2'b00;
  assign RRESP = 2'b00;

  // Byte-offset address bits select nothing; fold them away explicitly.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // NOTE: every signal in this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    aw_hs     = AWVALID & AWREADY;
    w_hs      = WVALID & WREADY;
    b_hs      = BVALID & BREADY;
    ar_hs     = ARVALID & ARREADY;
    commit    = aw_held_q & w_held_q & ~BVALID;
    aw_held_d = b_hs ? 1'b0 : (aw_held_q | aw_hs);
    w_held_d  = b_hs ? 1'b0 : (w_held_q | w_hs);
    bvalid_d  = commit | (BVALID & ~BREADY);
    rvalid_d  = ar_hs | (RVALID & ~RREADY);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      if (aw_hs) aw_idx_q <= AWADDR[S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      // Readies stay low from capture until the write response is accepted.
      AWREADY <= ~aw_held_d & ~bvalid_d;
      WREADY  <= ~w_held_d & ~bvalid_d;
      BVALID  <= bvalid_d;
    end
  end

  // NOTE: the register bank is architecturally visible state, so it is cleared by reset like any flop.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) regs[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // A read sharing an edge with a commit sees the pre-write contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
    end else begin
      if (ar_hs) RDATA <= regs[ARADDR[S_AXI_ADDR_WIDTH-1:ADDR_LSB]];
      RVALID  <= rvalid_d;
      ARREADY <= ~rvalid_d;
    end
  end

endmodule

// File: tb/tb_s_axil_register.sv
// Directed self-checking bench for s_axil_register.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_s_axil_register;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [5:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  s_axil_register dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, AWREADY, 0);
    check({tag, "_wready"},  WREADY,  0);
    check({tag, "_arready"}, ARREADY, 0);
    check({tag, "_bvalid"},  BVALID,  0);
    check({tag, "_rvalid"},  RVALID,  0);
    check({tag, "_rdata"},   RDATA,   0);
    check({tag, "_bresp"},   BRESP,   0);
    check({tag, "_rresp"},   RRESP,   0);
  endtask

  // Called at the falling edge where BVALID is expected high.
  task automatic b_complete(input string tag);
    check({tag, "_bvalid"}, BVALID, 1);
    check({tag, "_bresp"},  BRESP,  0);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, BVALID, 0);
    check({tag, "_awready_back"}, AWREADY, 1);
    check({tag, "_wready_back"},  WREADY,  1);
  endtask

  task automatic write(input logic [5:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input string tag);
    check({tag, "_awready_idle"}, AWREADY, 1);
    check({tag, "_wready_idle"},  WREADY,  1);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check({tag, "_awready_held"}, AWREADY, 0);
    check({tag, "_bvalid_early"}, BVALID, 0);
    @(negedge ACLK);
    b_complete(tag);
  endtask

  task automatic read(input logic [5:0] addr, input logic [31:0] exp, input string tag);
    check({tag, "_arready_idle"}, ARREADY, 1);
    ARADDR = addr; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check({tag, "_rvalid"},  RVALID,  1);
    check({tag, "_arready"}, ARREADY, 0);
    check({tag, "_rdata"},   RDATA,   exp);
    check({tag, "_rresp"},   RRESP,   0);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check({tag, "_rvalid_drop"},  RVALID,  0);
    check({tag, "_arready_back"}, ARREADY, 1);
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state and the first edge after release.
    #12;
    check_all_zero("rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("rst_rel_awready", AWREADY, 0);
    @(negedge ACLK);
    check("rst_rel_awready_up", AWREADY, 1);
    check("rst_rel_wready_up",  WREADY,  1);
    check("rst_rel_arready_up", ARREADY, 1);

    // Every register reads zero after reset.
    for (int a = 0; a < 16; a++) read(6'(a * 4), 32'h0000_0000, $sformatf("zero_%0d", a));

    // AW and W on the same edge.
    write(6'h04, 32'hDEAD_BEEF, 4'hF, "same_cycle");
    read(6'h04, 32'hDEAD_BEEF, "rd_04");

    // W three cycles ahead of AW.
    WDATA = 32'h1122_3344; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    check("wfirst_wready_held", WREADY, 0);
    repeat (3) begin
      check("wfirst_no_b", BVALID, 0);
      check("wfirst_awready", AWREADY, 1);
      @(negedge ACLK);
    end
    AWADDR = 6'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("wfirst_b_latency", BVALID, 0);
    @(negedge ACLK);
    b_complete("wfirst");
    read(6'h08, 32'h1122_3344, "rd_08");

    // Partial strobes and an unaligned address.
    write(6'h0C, 32'hFFFF_FFFF, 4'hF, "fill_0c");
    write(6'h0C, 32'h0000_0000, 4'h5, "strb5");
    read(6'h0C, 32'hFF00_FF00, "rd_strb5");
    write(6'h0D, 32'hAAAA_AAAA, 4'hF, "unaligned");
    read(6'h0C, 32'hAAAA_AAAA, "rd_unaligned");

    // Zero strobe completes with no change.
    write(6'h04, 32'h1234_5678, 4'h0, "strb0");
    read(6'h04, 32'hDEAD_BEEF, "rd_strb0");

    // Read and commit on the same edge to the same register.
    AWADDR = 6'h04; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 6'h04; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("collide_rvalid", RVALID, 1);
    check("collide_rdata_old", RDATA, 32'hDEAD_BEEF);
    check("collide_bvalid", BVALID, 1);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    check("collide_bvalid_drop", BVALID, 0);
    check("collide_rvalid_drop", RVALID, 0);
    read(6'h04, 32'h0BAD_F00D, "rd_collide_new");

    // Back-pressure on B and R for five cycles.
    AWADDR = 6'h18; WDATA = 32'h5A5A_C3C3; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    repeat (5) begin
      check("bstall_bvalid", BVALID, 1);
      check("bstall_awready", AWREADY, 0);
      check("bstall_wready", WREADY, 0);
      @(negedge ACLK);
    end
    b_complete("bstall");
    ARADDR = 6'h18; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    ARADDR = 6'h00;
    repeat (5) begin
      check("rstall_rvalid", RVALID, 1);
      check("rstall_rdata", RDATA, 32'h5A5A_C3C3);
      check("rstall_arready", ARREADY, 0);
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("rstall_rvalid_drop", RVALID, 0);

    // BREADY and RREADY raised before VALID.
    BREADY = 1'b1;
    AWADDR = 6'h1C; WDATA = 32'h0123_4567; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("early_b_wait", BVALID, 0);
    @(negedge ACLK);
    check("early_b_up", BVALID, 1);
    @(negedge ACLK);
    check("early_b_done", BVALID, 0);
    check("early_b_awready", AWREADY, 1);
    BREADY = 1'b0;
    RREADY = 1'b1;
    ARADDR = 6'h1C; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("early_r_up", RVALID, 1);
    check("early_r_data", RDATA, 32'h0123_4567);
    @(negedge ACLK);
    check("early_r_done", RVALID, 0);
    RREADY = 1'b0;

    // Reset between AW and W aborts the write.
    AWADDR = 6'h10; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("abort_aw_taken", AWREADY, 0);
    ARESET = 1'b1;
    #1;
    check_all_zero("abort_rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("abort_awready", AWREADY, 1);
    check("abort_wready",  WREADY,  1);
    check("abort_arready", ARREADY, 1);
    read(6'h10, 32'h0000_0000, "abort_rd_10");
    read(6'h04, 32'h0000_0000, "abort_rd_04");
    WDATA = 32'hCAFE_0001; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    repeat (3) begin
      check("abort_no_stale_b", BVALID, 0);
      @(negedge ACLK);
    end
    AWADDR = 6'h14; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    @(negedge ACLK);
    b_complete("abort_after");
    read(6'h14, 32'hCAFE_0001, "abort_rd_14");
    read(6'h10, 32'h0000_0000, "abort_rd_10_again");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
